// File: rtl/darkbus_pkg.sv
// Shared types for the dark RAM bus arbiter.
// Owns the FSM encoding and per-master control bundle.
package darkbus_pkg;

  localparam int ARB_NM = 2;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DONE
  } arb_state_t;

  typedef struct packed {
    logic req;
    logic we;
    logic lock;
  } mreq_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick.
// A tie goes to the master that did not win last.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       owner_o
);

  // tie -> other than last; else the sole requester
  always_comb begin
    owner_o = 1'b0;
    unique case (1'b1)
      (req_i == 2'b11): owner_o = ~last_i;
      (req_i == 2'b10): owner_o = 1'b1;
      default:          owner_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/darkedram_arbiter.sv
// Two-master arbiter for the on-chip RAM slave port.
// Round-robin, optional locked pairs, bus watchdog.
module darkedram_arbiter
  import darkbus_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            XCLK,
  input  logic            XRES,
  input  logic            M0_REQ,
  input  logic            M0_WE,
  input  logic [DW/8-1:0] M0_BE,
  input  logic [AW-1:0]   M0_ADDR,
  input  logic [DW-1:0]   M0_WDATA,
  input  logic            M0_LOCK,
  output logic            M0_ACK,
  output logic            M0_ERR,
  output logic [DW-1:0]   M0_RDATA,
  input  logic            M1_REQ,
  input  logic            M1_WE,
  input  logic [DW/8-1:0] M1_BE,
  input  logic [AW-1:0]   M1_ADDR,
  input  logic [DW-1:0]   M1_WDATA,
  input  logic            M1_LOCK,
  output logic            M1_ACK,
  output logic            M1_ERR,
  output logic [DW-1:0]   M1_RDATA,
  output logic            S_EN,
  output logic            S_WE,
  output logic            S_RE,
  output logic [DW/8-1:0] S_BE,
  output logic [AW-1:0]   S_ADDR,
  output logic [DW-1:0]   S_WDATA,
  input  logic [DW-1:0]   S_RDATA,
  input  logic            S_WACK,
  input  logic            S_RACK
);

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  arb_state_t state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [7:0] wdog_q, wdog_d;

  mreq_t           r0, r1, own;
  logic            pick;
  logic            act, sack, ok, tmo, done;
  logic [DW/8-1:0] own_be;
  logic [AW-1:0]   own_addr;
  logic [DW-1:0]   own_wdata;
  logic [DW-1:0]   rd;

  assign r0 = {M0_REQ, M0_WE, M0_LOCK};
  assign r1 = {M1_REQ, M1_WE, M1_LOCK};

  rr_pick2 u_pick (
    .req_i   ({M1_REQ, M0_REQ}),
    .last_i  (last_q),
    .owner_o (pick)
  );

  // owner request mux
  always_comb begin
    own       = owner_q ? r1 : r0;
    own_be    = owner_q ? M1_BE : M0_BE;
    own_addr  = owner_q ? M1_ADDR : M0_ADDR;
    own_wdata = owner_q ? M1_WDATA : M0_WDATA;
  end

  // bus only driven while the owner still holds REQ,
  // so a dropped request can never start a write
  always_comb begin
    act  = (state_q == GRANT) && own.req;
    sack = S_WACK | S_RACK;
    ok   = act & sack;
    tmo  = act & ~sack & (wdog_q == WD_LAST);
    done = ok | tmo;
  end

  // slave side strobes and forwarded fields
  always_comb begin
    S_EN    = act;
    S_WE    = act & own.we;
    S_RE    = act & ~own.we;
    S_BE    = act ? own_be : '0;
    S_ADDR  = act ? own_addr : '0;
    S_WDATA = act ? own_wdata : '0;
  end

  // master side completions; non-owner sees zeros
  always_comb begin
    rd       = (ok & ~own.we) ? S_RDATA : '0;
    M0_ACK   = done & ~owner_q;
    M1_ACK   = done & owner_q;
    M0_ERR   = tmo & ~owner_q;
    M1_ERR   = tmo & owner_q;
    M0_RDATA = owner_q ? '0 : rd;
    M1_RDATA = owner_q ? rd : '0;
  end

  // next state, owner, fairness and watchdog
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      IDLE: begin
        if (M0_REQ | M1_REQ) begin
          owner_d = pick;
          wdog_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!own.req) begin
          wdog_d  = '0;
          state_d = DONE;
        end else if (ok) begin
          last_d  = owner_q;
          wdog_d  = '0;
          state_d = own.lock ? GRANT : DONE;
        end else if (tmo) begin
          last_d  = owner_q;
          wdog_d  = '0;
          state_d = DONE;
        end else begin
          wdog_d  = wdog_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state registers
  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule
